uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-byte arbiter sharing one buart transmitter
// Optional per-requester lock keeps the grant across a packet; an idle lock is force-released.
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              uart_wr,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_busy,
  output logic              timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAITB,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  int              cand;
  logic            owner_valid;
  logic            owner_lock;
  logic [7:0]      owner_byte;
  logic [IW-1:0]   next_ptr;

  // First valid requester searching from rr_ptr upward, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_lock  = req_lock[owner_q];
  assign owner_byte  = req_data[{owner_q, 3'b000} +: 8];
  assign next_ptr    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    uart_wr   = 1'b0;
    req_ready = '0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!uart_busy && pick_found) begin
          owner_d = pick_idx;
          data_d  = req_data[{pick_idx, 3'b000} +: 8];
          grant_d = NREQ'(1) << pick_idx;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        uart_wr   = 1'b1;
        req_ready = grant_q;
        state_d   = S_WAITB;
      end
      S_WAITB: begin
        if (uart_busy) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!uart_busy) begin
          if (owner_lock && owner_valid) begin
            data_d  = owner_byte;
            state_d = S_SEND;
          end else if (owner_lock) begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (owner_valid) begin
          data_d  = owner_byte;
          state_d = S_SEND;
        end else if (!owner_lock) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end else if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
          // This cycle's increment would reach the limit: release now.
          timeout  = 1'b1;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant        = grant_q;
  assign uart_tx_data = data_q;

endmodule
